// File: rtl/grf_wr_arbiter_pkg.sv
// Shared types for the GRF write-port arbiter.
// Entry bundle carried by the long-unit result FIFO and the starvation FSM states.
package grf_wr_arbiter_pkg;

  localparam int GRF_AW = 5;
  localparam int GRF_DW = 32;
  localparam int PC_W   = 32;
  localparam int NREG   = 1 << GRF_AW;

  typedef struct packed {
    logic [GRF_AW-1:0] addr;
    logic [GRF_DW-1:0] data;
    logic [PC_W-1:0]   pc;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STALL = 2'd2
  } starve_e;

endpackage

// File: rtl/grf_wr_arbiter_if.sv
// Long-unit result handshake into the GRF write arbiter.
// master = long unit, slave = arbiter.
interface grf_wr_arbiter_if;
  import grf_wr_arbiter_pkg::*;

  logic              l_valid;
  logic              l_ready;
  logic [GRF_AW-1:0] l_addr;
  logic [GRF_DW-1:0] l_data;
  logic [PC_W-1:0]   l_pc;

  modport master (
    output l_valid, l_addr, l_data, l_pc,
    input  l_ready
  );

  modport slave (
    input  l_valid, l_addr, l_data, l_pc,
    output l_ready
  );

endinterface

// File: rtl/grf_wr_arbiter_fifo.sv
// Small result FIFO for long-unit writes.
// Head is visible combinationally; pointers wrap modulo DEPTH.
module grf_wr_arbiter_fifo
  import grf_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_push,
  input  entry_t i_din,
  input  logic   i_pop,
  output entry_t o_head,
  output logic   o_full,
  output logic   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_cnt;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/grf_wr_arbiter.sv
// Shares the GRF write port between the W stage and the long unit.
// Pipeline wins; long results queue, with busy scoreboard and starvation stall.
module grf_wr_arbiter
  import grf_wr_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_we,
  input  logic [GRF_AW-1:0] p_addr,
  input  logic [GRF_DW-1:0] p_data,
  input  logic [PC_W-1:0]   p_pc,
  input  logic              iss_valid,
  input  logic [GRF_AW-1:0] iss_addr,
  grf_wr_arbiter_if.slave   lu,
  output logic [GRF_AW-1:0] A3,
  output logic [GRF_DW-1:0] WD3,
  output logic              regwrite,
  output logic [PC_W-1:0]   pc_new,
  output logic [NREG-1:0]   busy,
  output logic              stall_req
);

  localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;

  entry_t           w_head;
  entry_t           w_din;
  logic             w_full;
  logic             w_empty;
  logic             w_pgrant;
  logic             w_pop;
  logic             w_push;
  logic [NREG-1:0]  w_busy_nxt;
  logic [NREG-1:0]  r_busy;
  starve_e          r_st;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stall;

  assign w_pgrant   = p_we && (p_addr != '0);
  assign w_pop      = !w_pgrant && !w_empty;
  assign w_push     = lu.l_valid && !w_full;
  assign lu.l_ready = !w_full;
  assign w_din      = '{addr: lu.l_addr, data: lu.l_data, pc: lu.l_pc};
  assign busy       = r_busy;
  assign stall_req  = r_stall;

  grf_wr_arbiter_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Reset gates the port so nothing half-formed reaches the GRF.
  always_comb begin
    regwrite = 1'b0;
    A3       = '0;
    WD3      = '0;
    pc_new   = '0;
    if (reset) begin
      if (w_pgrant) begin
        regwrite = 1'b1;
        A3       = p_addr;
        WD3      = p_data;
        pc_new   = p_pc;
      end else if (!w_empty) begin
        regwrite = (w_head.addr != '0);
        A3       = w_head.addr;
        WD3      = w_head.data;
        pc_new   = w_head.pc;
      end
    end
  end

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) w_busy_nxt[w_head.addr] = 1'b0;
    if (iss_valid) w_busy_nxt[iss_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_st    <= ST_IDLE;
      r_cnt   <= '0;
      r_stall <= 1'b0;
    end else if (w_pop) begin
      r_st    <= ST_IDLE;
      r_cnt   <= '0;
      r_stall <= 1'b0;
    end else begin
      unique case (r_st)
        ST_IDLE, ST_WAIT: begin
          if (!w_empty) begin
            if (r_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
              r_st    <= ST_STALL;
              r_stall <= 1'b1;
            end else begin
              r_st  <= ST_WAIT;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_STALL: r_stall <= 1'b1;
        default:  r_st    <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Bench for grf_wr_arbiter: directed scenarios then constrained-random traffic
// checked against a queue-based model of the write port.
module tb_grf_wr_arbiter;
  import grf_wr_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        p_we;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic [31:0] p_pc;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        regwrite;
  logic [31:0] pc_new;
  logic [31:0] busy;
  logic        stall_req;

  grf_wr_arbiter_if lu ();

  grf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .p_we      (p_we),
    .p_addr    (p_addr),
    .p_data    (p_data),
    .p_pc      (p_pc),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .lu        (lu),
    .A3        (A3),
    .WD3       (WD3),
    .regwrite  (regwrite),
    .pc_new    (pc_new),
    .busy      (busy),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  entry_t      mq[$];
  logic [4:0]  pend[$];
  logic [31:0] m_busy;
  int          age;
  bit          m_stall;
  int          n_chk, n_pass, n_fail;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend.delete();
    m_busy  = '0;
    age     = 0;
    m_stall = 1'b0;
  endtask

  // One clock: check outputs, advance model at the edge, return at negedge.
  task automatic cyc();
    entry_t h, e;
    bit pg, ne, pop, acc, ew;
    logic [4:0] ea;
    logic [31:0] ed, ep;
    #1;
    pg = p_we && (p_addr != 0);
    ne = mq.size() > 0;
    ew = 0; ea = 0; ed = 0; ep = 0;
    if (pg) begin
      ew = 1; ea = p_addr; ed = p_data; ep = p_pc;
    end else if (ne) begin
      ew = (mq[0].addr != 0); ea = mq[0].addr; ed = mq[0].data; ep = mq[0].pc;
    end
    chk("regwrite", regwrite, ew);
    chk("A3", A3, ea);
    chk("WD3", WD3, ed);
    chk("pc_new", pc_new, ep);
    chk("l_ready", lu.l_ready, mq.size() < DEPTH);
    chk("busy", busy, m_busy);
    chk("stall_req", stall_req, m_stall);
    chk("write_r0", regwrite && (A3 == 0), 0);
    acc = lu.l_valid && (mq.size() < DEPTH);
    pop = !pg && ne;
    @(posedge clk);
    if (pop) begin
      h = mq.pop_front();
      m_busy[h.addr] = 1'b0;
      age = 0;
      m_stall = 1'b0;
    end else if (ne) begin
      age++;
      if (age >= LIMIT) m_stall = 1'b1;
    end
    if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    m_busy[0] = 1'b0;
    if (acc) begin
      e.addr = lu.l_addr; e.data = lu.l_data; e.pc = lu.l_pc;
      mq.push_back(e);
    end
    @(negedge clk);
    if (acc) lu.l_valid = 1'b0;
  endtask

  task automatic lsend(input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] pc);
    lu.l_valid = 1'b1;
    lu.l_addr  = a;
    lu.l_data  = d;
    lu.l_pc    = pc;
  endtask

  task automatic issue(input logic [4:0] a);
    iss_valid = 1'b1;
    iss_addr  = a;
    cyc();
    iss_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [4:0] a;
    n_chk = 0; n_pass = 0; n_fail = 0;
    model_reset();
    p_we = 1'b1; p_addr = 5'd3; p_data = 32'hCAFE; p_pc = 32'h10;
    iss_valid = 1'b0; iss_addr = '0;
    lu.l_valid = 1'b0; lu.l_addr = '0; lu.l_data = '0; lu.l_pc = '0;

    // Reset held with a pipeline write pending: port must stay quiet
    repeat (2) @(negedge clk);
    chk("rst_regwrite", regwrite, 0);
    chk("rst_A3", A3, 0);
    chk("rst_WD3", WD3, 0);
    chk("rst_pc_new", pc_new, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall_req, 0);
    reset = 1'b1;
    p_we = 1'b0;
    cyc();

    // Issue $8, result arrives, written next cycle, busy clears after
    issue(5'd8);
    lsend(5'd8, 32'h1234, 32'h3000);
    #1 chk("t2_busy8_set", busy[8], 1);
    cyc();
    #1;
    chk("t2_regwrite", regwrite, 1);
    chk("t2_A3", A3, 8);
    chk("t2_WD3", WD3, 32'h1234);
    chk("t2_pc_new", pc_new, 32'h3000);
    cyc();
    #1 chk("t2_busy8_clr", busy[8], 0);

    // Pipeline write and long result in the same cycle
    issue(5'd9);
    p_we = 1'b1; p_addr = 5'd5; p_data = 32'hAA; p_pc = 32'h100;
    lsend(5'd9, 32'h99, 32'h3004);
    #1 chk("t3_pipe_A3", A3, 5);
    cyc();
    p_we = 1'b0;
    #1 chk("t3_long_A3", A3, 9);
    chk("t3_long_WD3", WD3, 32'h99);
    cyc();

    // Fill the FIFO while the pipeline holds the port
    issue(5'd10);
    issue(5'd11);
    issue(5'd12);
    p_we = 1'b1; p_addr = 5'd5;
    lsend(5'd10, 32'h1010, 32'h2000); cyc();
    lsend(5'd11, 32'h1111, 32'h2004); cyc();
    lsend(5'd12, 32'h1212, 32'h2008);
    #1 chk("t4_full_ready", lu.l_ready, 0);
    k = 0;
    while (lu.l_valid && k < 20) begin
      p_we = !stall_req;
      cyc();
      k++;
    end
    chk("t4_accept", lu.l_valid, 0);
    p_we = 1'b0;
    repeat (4) cyc();
    chk("t4_drained", busy[12:10], 0);

    // Starvation: stall_req rises STARVE_LIMIT edges after enqueue
    issue(5'd13);
    p_we = 1'b1; p_addr = 5'd6;
    lsend(5'd13, 32'h1313, 32'h2100);
    cyc();
    k = 0;
    while (!stall_req && k < 10) begin
      p_addr = 5'd6 + 5'(k % 2);
      p_data = $urandom;
      cyc();
      k++;
    end
    chk("t5_stall_rise", k, LIMIT);
    p_we = 1'b0;
    #1 chk("t5_stall_hold", stall_req, 1);
    cyc();
    #1 chk("t5_stall_fall", stall_req, 0);

    // Writes targeting $0 never reach the GRF
    issue(5'd0);
    lsend(5'd0, 32'hDEAD, 32'h4000);
    cyc();
    #1 chk("t6_long_r0", regwrite, 0);
    chk("t6_busy0", busy[0], 0);
    cyc();
    p_we = 1'b1; p_addr = 5'd0; p_data = 32'hBEEF;
    #1 chk("t6_pipe_r0", regwrite, 0);
    cyc();

    // Reset mid-stream with two queued entries
    issue(5'd14);
    issue(5'd15);
    p_we = 1'b1; p_addr = 5'd7;
    lsend(5'd14, 32'h1414, 32'h5000); cyc();
    lsend(5'd15, 32'h1515, 32'h5004); cyc();
    chk("t7_queued", mq.size(), 2);
    reset = 1'b0;
    #1;
    chk("t7_rst_regwrite", regwrite, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_A3", A3, 0);
    model_reset();
    lu.l_valid = 1'b0;
    p_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("t7_ready_after", lu.l_ready, 1);
    cyc();

    // Constrained-random traffic obeying the decode/stall protocol
    for (int c = 0; c < 800; c++) begin
      p_we   = !m_stall && ($urandom_range(0, 99) < 70);
      a      = 5'($urandom_range(0, 31));
      p_addr = m_busy[a] ? 5'd0 : a;
      p_data = $urandom;
      p_pc   = $urandom;
      iss_valid = 1'b0;
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) < 30 && !m_busy[a] &&
          (pend.size() + mq.size()) < 6) begin
        iss_valid = 1'b1;
        iss_addr  = a;
      end
      if (!lu.l_valid && pend.size() > 0 && $urandom_range(0, 1) == 1)
        lsend(pend.pop_front(), $urandom, $urandom);
      cyc();
      if (iss_valid) pend.push_back(iss_addr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
